// File: rtl/mips_mem_responder.sv
// Memory responder for the multi-cycle MIPS core: 1-cycle instruction fetch port plus
// a busy/valid data port with wait states, big-endian byte/half/word lanes and error reporting.
module mips_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 327680,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_out,
  output logic        instr_err,
  input  logic        data_req,
  input  logic        data_rd_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_busy,
  output logic        data_valid,
  output logic        data_err
);
  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS) * 32'd4;
  localparam logic [7:0]  WAIT_INIT = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  logic [31:0] mem_q [DEPTH_WORDS];

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        rd_q;
  logic        busy_q, valid_q, err_q;
  logic [31:0] rdata_q, instr_q;
  logic        ierr_q;

  // Instruction-side decode
  logic [31:0]      ioff;
  logic [IDX_W-1:0] iidx;
  logic             ibad;

  // Data-side decode, always from the captured request
  logic [31:0]      doff, dcur, drsel, dwmerge;
  logic [IDX_W-1:0] didx;
  logic             door, derr;
  logic [4:0]       bsh, hsh;

  always_comb begin
    ioff = instr_addr - BASE_ADDR;
    iidx = ioff[IDX_W+1:2];
    ibad = (instr_addr[1:0] != 2'b00) || (ioff >= SPAN);

    doff = addr_q - BASE_ADDR;
    didx = doff[IDX_W+1:2];
    door = (doff >= SPAN);
    derr = (size_q == 2'b11) || door ||
           (size_q == 2'b01 && addr_q[0]) ||
           (size_q == 2'b10 && addr_q[1:0] != 2'b00);
    dcur = door ? 32'h0 : mem_q[didx];
    // Big-endian: lane 0 lives in the top byte, so shift by (3 - lane) bytes
    bsh  = {~addr_q[1:0], 3'b000};
    hsh  = {~addr_q[1], 4'b0000};

    drsel   = dcur;
    dwmerge = wdata_q;
    case (size_q)
      2'b00: begin
        drsel   = {24'h0, 8'(dcur >> bsh)};
        dwmerge = (dcur & ~(32'h0000_00FF << bsh)) | ({24'h0, wdata_q[7:0]} << bsh);
      end
      2'b01: begin
        drsel   = {16'h0, 16'(dcur >> hsh)};
        dwmerge = (dcur & ~(32'h0000_FFFF << hsh)) | ({16'h0, wdata_q[15:0]} << hsh);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'h0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      instr_q <= 32'h0;
      ierr_q  <= 1'b0;
    end else begin
      // Non-blocking read returns the pre-write word on a same-edge store
      instr_q <= ibad ? 32'h0 : mem_q[iidx];
      ierr_q  <= ibad;
      case (state_q)
        S_IDLE: if (data_req) begin
          addr_q  <= data_addr;
          size_q  <= data_size;
          rd_q    <= data_rd_wr;
          wdata_q <= data_wdata;
          busy_q  <= 1'b1;
          cnt_q   <= WAIT_INIT;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q != 8'h0) begin
            cnt_q <= cnt_q - 8'h1;
          end else begin
            valid_q <= 1'b1;
            err_q   <= derr;
            if (derr)      rdata_q      <= 32'h0;
            else if (rd_q) rdata_q      <= drsel;
            else           mem_q[didx]  <= dwmerge;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          valid_q <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr_out  = instr_q;
  assign instr_err  = ierr_q;
  assign data_rdata = rdata_q;
  assign data_busy  = busy_q;
  assign data_valid = valid_q;
  assign data_err   = err_q;
endmodule

// File: tb/tb_mips_mem_responder.sv
// Scoreboard bench: directed data/fetch vectors on a WAIT_CYCLES=2 instance and a
// back-to-back handshake run on a WAIT_CYCLES=0 instance.
module tb_mips_mem_responder;
  typedef struct packed { logic [31:0] rdata; logic err; } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] iaddr = 32'h0;
  logic        req = 1'b0, rd_wr = 1'b0;
  logic [1:0]  size = 2'b10;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [31:0] instr_out, rdata;
  logic        ierr, busy, valid, err;

  logic        req0 = 1'b0;
  logic [31:0] instr_out0, rdata0;
  logic        ierr0, busy0, valid0, err0;

  int n_cmp = 0, n_bad = 0;
  exp_t q_main[$];
  exp_t q_hs[$];

  mips_mem_responder #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .instr_addr(iaddr), .instr_out(instr_out), .instr_err(ierr),
    .data_req(req), .data_rd_wr(rd_wr), .data_size(size), .data_addr(addr),
    .data_wdata(wdata), .data_rdata(rdata), .data_busy(busy), .data_valid(valid),
    .data_err(err));

  mips_mem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .instr_addr(32'h8000_0000), .instr_out(instr_out0),
    .instr_err(ierr0), .data_req(req0), .data_rd_wr(1'b1), .data_size(2'b11),
    .data_addr(32'h8000_0000), .data_wdata(32'h0), .data_rdata(rdata0), .data_busy(busy0),
    .data_valid(valid0), .data_err(err0));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitors: pop the expected response whenever a completion strobe appears
  always @(negedge clk) begin
    exp_t e;
    if (valid) begin
      if (q_main.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL main_unexpected_valid: got valid=1 expected none");
      end else begin
        e = q_main.pop_front();
        chk("main_rdata", rdata, e.rdata);
        chk("main_err", {31'h0, err}, {31'h0, e.err});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (valid0) begin
      if (q_hs.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL hs_unexpected_valid: got valid=1 expected none");
      end else begin
        e = q_hs.pop_front();
        chk("hs_rdata", rdata0, e.rdata);
        chk("hs_err", {31'h0, err0}, {31'h0, e.err});
      end
    end
  end

  // One data transaction; called at #1 after an edge with the port idle
  task automatic xfer(input string nm, input logic rd, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] erd, input logic eerr,
                      output logic [31:0] ic);
    int lat;
    req = 1'b1; rd_wr = rd; size = sz; addr = a; wdata = wd;
    q_main.push_back(exp_t'{rdata: erd, err: eerr});
    @(posedge clk); #1;
    chk({nm, "_busy_after_accept"}, {31'h0, busy}, 32'h1);
    // Scramble inputs: the captured request must not follow them
    req = 1'b0; rd_wr = ~rd; size = ~sz; addr = ~a; wdata = ~wd;
    lat = 0;
    while (!valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    ic = instr_out;
    chk({nm, "_latency"}, lat, 32'd3);
    @(posedge clk); #1;
    chk({nm, "_valid_one_cycle"}, {30'h0, valid, busy}, 32'h0);
  endtask

  initial begin
    logic [31:0] ic;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Preload through the data port; reset must not clear memory
    xfer("preload", 1'b0, 2'b10, 32'h8002_0000, 32'h27BD_FFE8, 32'h0, 1'b0, ic);

    reset = 1'b1; iaddr = 32'h8002_0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr_out", instr_out, 32'h0);
    chk("rst_instr_err", {31'h0, ierr}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busy_valid_err", {29'h0, busy, valid, err}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("fetch_word", instr_out, 32'h27BD_FFE8);
    chk("fetch_err", {31'h0, ierr}, 32'h0);

    xfer("wr_deadbeef", 1'b0, 2'b10, 32'h8011_FFFC, 32'hDEAD_BEEF, 32'h0, 1'b0, ic);
    xfer("rd_deadbeef", 1'b1, 2'b10, 32'h8011_FFFC, 32'h0, 32'hDEAD_BEEF, 1'b0, ic);

    xfer("wr_11223344", 1'b0, 2'b10, 32'h8010_0000, 32'h1122_3344, 32'hDEAD_BEEF, 1'b0, ic);
    iaddr = 32'h8010_0000;
    xfer("wr_byte_aa", 1'b0, 2'b00, 32'h8010_0002, 32'h0000_00AA, 32'hDEAD_BEEF, 1'b0, ic);
    chk("fetch_read_before_write", ic, 32'h1122_3344);
    chk("fetch_after_write", instr_out, 32'h1122_AA44);
    xfer("rd_word_lane", 1'b1, 2'b10, 32'h8010_0000, 32'h0, 32'h1122_AA44, 1'b0, ic);
    xfer("rd_byte1", 1'b1, 2'b00, 32'h8010_0001, 32'h0, 32'h0000_0022, 1'b0, ic);
    xfer("rd_half2", 1'b1, 2'b01, 32'h8010_0002, 32'h0, 32'h0000_AA44, 1'b0, ic);
    xfer("rd_byte3", 1'b1, 2'b00, 32'h8010_0003, 32'h0, 32'h0000_0044, 1'b0, ic);
    xfer("rd_half0", 1'b1, 2'b01, 32'h8010_0000, 32'h0, 32'h0000_1122, 1'b0, ic);

    xfer("err_word_misalign", 1'b1, 2'b10, 32'h8010_0002, 32'h0, 32'h0, 1'b1, ic);
    xfer("wr_last_word", 1'b0, 2'b10, 32'h8013_FFFC, 32'h55AA_55AA, 32'h0, 1'b0, ic);
    xfer("err_wr_oor", 1'b0, 2'b10, 32'h8014_0000, 32'hFFFF_FFFF, 32'h0, 1'b1, ic);
    xfer("rd_last_word", 1'b1, 2'b10, 32'h8013_FFFC, 32'h0, 32'h55AA_55AA, 1'b0, ic);
    xfer("err_half_misalign", 1'b0, 2'b01, 32'h8010_0001, 32'h0000_BEEF, 32'h0, 1'b1, ic);
    xfer("err_size11", 1'b1, 2'b11, 32'h8010_0000, 32'h0, 32'h0, 1'b1, ic);
    xfer("rd_unchanged", 1'b1, 2'b10, 32'h8010_0000, 32'h0, 32'h1122_AA44, 1'b0, ic);
    xfer("wr_half0", 1'b0, 2'b01, 32'h8010_0000, 32'h0000_BEEF, 32'h1122_AA44, 1'b0, ic);
    xfer("rd_half_merged", 1'b1, 2'b10, 32'h8010_0000, 32'h0, 32'hBEEF_AA44, 1'b0, ic);
    xfer("err_rd_below_base", 1'b1, 2'b10, 32'h7FFF_FFFC, 32'h0, 32'h0, 1'b1, ic);

    iaddr = 32'h7FFF_FFFC;
    @(posedge clk); #1;
    chk("fetch_below_base", {instr_out[30:0], ierr}, 32'h1);
    iaddr = 32'h8002_0002;
    @(posedge clk); #1;
    chk("fetch_misalign", {instr_out[30:0], ierr}, 32'h1);
    iaddr = 32'h8014_0000;
    @(posedge clk); #1;
    chk("fetch_oor", {instr_out[30:0], ierr}, 32'h1);

    // Reset landing on the commit edge cancels the store and the strobe
    xfer("wr_zero", 1'b0, 2'b10, 32'h8010_0010, 32'h0, 32'h0, 1'b0, ic);
    req = 1'b1; rd_wr = 1'b0; size = 2'b10; addr = 32'h8010_0010; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_no_valid", {30'h0, valid, busy}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_still_idle", {30'h0, valid, busy}, 32'h0);
    xfer("rd_after_midrst", 1'b1, 2'b10, 32'h8010_0010, 32'h0, 32'h0, 1'b0, ic);

    // Back-to-back requests with zero wait states: busy 2 of 3, valid 1 of 3
    repeat (10) q_hs.push_back(exp_t'{rdata: 32'h0, err: 1'b1});
    req0 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      chk("hs_busy", {31'h0, busy0}, {31'h0, (i % 3) != 2});
      chk("hs_valid", {31'h0, valid0}, {31'h0, (i % 3) == 1});
    end
    req0 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("hs_queue_drained", q_hs.size(), 32'h0);
    chk("main_queue_drained", q_main.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
- Memory-side responder for the multi-cycle MIPS core's instruction and data interfaces.
- Serves two paths:
  - Instruction fetch: a registered read with a fixed 1-cycle latency.
  - Data load/store: a request/busy/valid handshake with programmable wait states, byte/half/word sizes, and error reporting.
- Sits between the core and the testbench/system. It is the sole backing store for program text, stack and data.

Parameters:
- BASE_ADDR, 32'h80000000, byte address that maps to word 0.
- DEPTH_WORDS, 327680, number of 32-bit words. Covers 0x80000000–0x8013FFFF.
- WAIT_CYCLES, 2, extra data-path wait states, range 0..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- instr_addr  input  32  byte address of the fetch.
- instr_out  output  32  fetched word, registered.
- instr_err  output  1  fetch address was misaligned or out of range.
- data_req  input  1  data request. Sampled only while data_busy=0.
- data_rd_wr  input  1  1 = read, 0 = write.
- data_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- data_addr  input  32  byte address.
- data_wdata  input  32  store data, right-justified.
- data_rdata  output  32  load data, right-justified and zero-extended.
- data_busy  output  1  request in progress.
- data_valid  output  1  one-cycle completion strobe.
- data_err  output  1  qualifies data_valid. Set when the access was rejected.

Behaviour:
- Reset (synchronous, applied at the edge while reset=1):
  - instr_out=0, instr_err=0, data_rdata=0, data_busy=0, data_valid=0, data_err=0, FSM=IDLE, wait counter=0.
  - Memory contents are NOT cleared.
- Addressing:
  - offset = addr - BASE_ADDR (32-bit unsigned); word index = offset[31:2].
  - An access is in range iff offset < DEPTH_WORDS*4.
  - Byte order is big-endian: byte lane 0 (addr[1:0]=00) is bits [31:24]; half at addr[1]=0 is bits [31:16].
- Instruction path:
  - Every edge, instr_out <= mem[word index of instr_addr]; latency is exactly 1 cycle.
  - If instr_addr[1:0]!=0 or it is out of range: instr_out <= 32'h00000000 (NOP) and instr_err <= 1. Otherwise instr_err <= 0.
  - If a data write commits on the same edge to the same word, instr_out returns the old contents (read-before-write).
- Data path FSM (IDLE, WAIT, RESP):
  - IDLE: when data_req=1, capture addr, size, rd_wr and wdata; set data_busy<=1 and count<=WAIT_CYCLES; go to WAIT. data_req=0 stays in IDLE.
  - WAIT, count!=0: count<=count-1.
  - WAIT, count==0 (commit edge):
    - Perform the access. Set data_valid<=1 and data_err per the error rules; go to RESP.
    - Read: data_rdata <= the selected byte/half/word, zero-extended.
    - Write: update only the addressed lane(s) from data_wdata[7:0], [15:0] or [31:0].
  - RESP: data_valid<=0, data_err<=0, data_busy<=0; go to IDLE.
  - A request accepted at edge N has data_valid high in the cycle after edge N+1+WAIT_CYCLES. It is accepted no earlier than edge N+WAIT_CYCLES+3.
  - data_req is ignored while busy. Inputs may change after acceptance without effect.
- Errors (checked at the commit edge):
  - Conditions: size=11; half with addr[0]=1; word with addr[1:0]!=0; out of range.
  - Required response: no memory update, data_rdata<=0, data_err<=1 with data_valid.
- Reset mid-transaction: reset wins at any edge, including the commit edge. No write occurs and no data_valid is issued.
- data_rdata holds its value until the next read or error commit. Writes leave data_rdata unchanged.

Test Plan:
- Reset and fetch:
  - Preload mem at 0x80020000 = 0x27BDFFE8.
  - Assert reset 2 cycles, release, drive instr_addr = 0x80020000.
  - Expect all outputs 0 during reset. Next cycle instr_out = 0x27BDFFE8, instr_err = 0.
- Word store then load, WAIT_CYCLES=2:
  - Write 0xDEADBEEF to 0x8011FFFC.
  - Expect data_valid one cycle, 3 edges after acceptance.
  - Read back the same address: data_rdata = 0xDEADBEEF, data_err = 0.
- Byte/half lanes:
  - Word 0x80100000 = 0x11223344.
  - Byte write 0xAA at 0x80100002 → word reads 0x1122AA44.
  - Byte read 0x80100001 → 0x00000022.
  - Half read 0x80100002 → 0x0000AA44.
- Errors:
  - Word read at 0x80100002 → data_valid=1, data_err=1, data_rdata=0.
  - Write to 0x80140000 → data_err=1 and memory unchanged.
  - instr_addr = 0x7FFFFFFC → instr_out = 0, instr_err = 1.
- Handshake:
  - Hold data_req high continuously with WAIT_CYCLES=0.
  - Expect data_valid every 3rd cycle and data_busy high 2 of every 3 cycles. No request is lost or duplicated.
- Reset mid-operation:
  - Issue a word write of 0x12345678 to 0x80100010 (prior value 0).
  - Assert reset on the commit edge.
  - Expect no data_valid. A later read returns 0x00000000.
